unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Sequencer and arbiter that shares one word-addressed memory array between the instruction-fetch requester and the data (load/store) requester of the multi-cycle CPU. It accepts held requests from both ports, runs one access at a time with a parameterised number of wait cycles, and returns a single-cycle acknowledge with registered read data. It sits between the CPU's fetch/memory-access states and the memory array, so instruction and data accesses never hit the array in the same cycle.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- WAIT_CYCLES, 2, extra memory cycles per access; legal range 0..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_ack  out  1  one-cycle fetch completion
- if_rdata  out  DATA_W  fetched word, valid while if_ack
- if_err  out  1  misaligned fetch, valid while if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle data completion
- d_rdata  out  DATA_W  load word, valid while d_ack
- d_err  out  1  misaligned data access, valid while d_ack
- mem_en  out  1  array access enable
- mem_we  out  1  array write strobe
- mem_addr  out  ADDR_W  array byte address
- mem_wdata  out  DATA_W  array write data
- mem_rdata  in  DATA_W  array read data, combinational from mem_addr
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: when any req is high, pick a winner and latch its id, address, we and wdata.
  - Aligned address (addr[1:0] == 0): go to ACCESS, loading wait counter = WAIT_CYCLES.
  - Misaligned address: go to RESP with err = 1 and rdata = 0; the array is never touched.
- ACCESS: mem_en = 1; mem_addr and mem_wdata are driven from the latched values.
  - Counter decrements each cycle.
  - At counter == 0: mem_we = latched we (final cycle only); reads capture mem_rdata into the rdata register; go to RESP.
- RESP: assert only the winner's ack for exactly one cycle, with rdata/err registered; then go to IDLE.
- Requester rule: drop req on the edge that samples ack. A req seen in IDLE is always a new request.
- Inputs are ignored outside IDLE; the latched copy is used.
- Default arbitration is fixed priority: data beats fetch.
- The non-winning request stays pending and is served on the next IDLE.

## Timing
- Reset values: if_ack = d_ack = 0, if_err = d_err = 0, if_rdata = d_rdata = 0, mem_en = mem_we = 0, mem_addr = mem_wdata = 0, busy = 0, state = IDLE, last-grant = fetch.
- Request seen in IDLE at cycle 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES+1.
  - ack is in cycle WAIT_CYCLES+2.
  - The next grant is possible no earlier than cycle WAIT_CYCLES+3 (IDLE).
- Misaligned access: ack in cycle 1.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
- Reset during ACCESS or RESP:
  - Return to IDLE immediately and drive all outputs to reset values.
  - A pending write is committed only if its final ACCESS edge already occurred.
  - No ack is issued for an aborted request.
- Counter is 4 bits and never wraps; the WAIT_CYCLES = 0 corner gives a single ACCESS cycle.

## Configuration
- Macro: UNIFIED_MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a simultaneous request, grant the port not recorded in last-grant; last-grant updates on every grant.
  - Reset last-grant = fetch, so the first tie goes to data.
- Undefined: fixed priority, data over fetch; the last-grant register is not built.

## Structure
- Shared package holds:
  - state encoding (IDLE/ACCESS/RESP);
  - requester ids (REQ_IF = 0, REQ_D = 1);
  - wait counter width (4);
  - the alignment mask constant.
- One sub-module, mem_arb_pick: the combinational winner select from if_req, d_req and last-grant. It contains the UNIFIED_MEM_ARB_RR_EN conditional.

## Test plan
- Fetch read, WAIT_CYCLES = 2, word 0x40 = 0x12345678, if_req at cycle 0:
  - mem_en high in cycles 1–3;
  - if_ack only in cycle 4 with if_rdata = 0x12345678;
  - d_ack stays 0.
- Store 0xDEADBEEF to 0x100, then load 0x100:
  - mem_we high only in cycle 3 of the store;
  - the load returns d_rdata = 0xDEADBEEF.
- Simultaneous if_req and d_req at cycle 0, fixed priority:
  - d_ack at cycle 4, if_ack at cycle 9.
  - With UNIFIED_MEM_ARB_RR_EN, two consecutive ties grant data, fetch, data, fetch.
- Misaligned d_addr = 0x102:
  - d_ack at cycle 1 with d_err = 1 and d_rdata = 0;
  - mem_en never high.
- rst pulsed in cycle 2 of a store to 0x200:
  - mem_we never asserts;
  - no d_ack;
  - a later read of 0x200 returns the old value;
  - busy = 0 after reset.
- WAIT_CYCLES = 0 fetch:
  - mem_en high in cycle 1 only;
  - if_ack in cycle 2.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Optional round-robin arbitration is selected with UNIFIED_MEM_ARB_RR_EN.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    localparam int unsigned CNT_W      = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    // Word alignment test on the two byte-offset bits.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Requester, array and status signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// UNIFIED_MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority.
module mem_arb_pick
    import unified_mem_arbiter_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
`ifdef UNIFIED_MEM_ARB_RR_EN
    input  req_id_e last_grant,
`endif
    output logic    grant_c,
    output req_id_e grant_id_c
);

    always_comb begin
        grant_c    = if_req | d_req;
        grant_id_c = REQ_IF;
`ifdef UNIFIED_MEM_ARB_RR_EN
        // On a tie, serve the port that did not win last time.
        if (if_req && d_req) begin
            grant_id_c = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
        end else if (d_req) begin
            grant_id_c = REQ_D;
        end
`else
        if (d_req) begin
            grant_id_c = REQ_D;
        end
`endif
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory array between fetch and data requesters, one access at a time.
// Define UNIFIED_MEM_ARB_RR_EN for round-robin arbitration (default: data over fetch).
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_id_e           id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              busy_q, busy_d;
    logic              grant_c;
    req_id_e           grant_id_c;
`ifdef UNIFIED_MEM_ARB_RR_EN
    req_id_e           lg_q, lg_d;
`endif

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
`ifdef UNIFIED_MEM_ARB_RR_EN
        .last_grant (lg_q),
`endif
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c)
    );

    // Next-state, request latch and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef UNIFIED_MEM_ARB_RR_EN
        lg_d    = lg_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    id_d = grant_id_c;
`ifdef UNIFIED_MEM_ARB_RR_EN
                    lg_d = grant_id_c;
`endif
                    if (grant_id_c == REQ_D) begin
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                    end else begin
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    // Misaligned requests complete without touching the array.
                    if (is_aligned(addr_d[1:0])) begin
                        state_d = ST_ACCESS;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        mem_en_d = (state_d == ST_ACCESS);
        mem_we_d = mem_en_d && (cnt_d == '0) && we_d;
        if_ack_d = (state_d == ST_RESP) && (id_d == REQ_IF);
        d_ack_d  = (state_d == ST_RESP) && (id_d == REQ_D);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            id_q     <= REQ_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UNIFIED_MEM_ARB_RR_EN
            lg_q     <= REQ_IF;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            if_ack_q <= if_ack_d;
            d_ack_q  <= d_ack_d;
            busy_q   <= busy_d;
`ifdef UNIFIED_MEM_ARB_RR_EN
            lg_q     <= lg_d;
`endif
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = rdata_q;
    assign bus.if_err    = err_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = rdata_q;
    assign bus.d_err     = err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;

endmodule
